phase_shift_loader: RTL and testbench

Frame sequencer and serial loader between the beam-steering phase LUT and the external phase-shifter chain. On `start` it latches a steering angle and walks the element index `piv` over all elements, enabling the LUT and capturing each 5-bit phase word. It shifts each word out on a bit-serial bus (`sclk`/`sdata`), then pulses `sle` so every element's phase shifter updates at the same time. It drives the LUT's `e_n`, `teta` and `piv` inputs and consumes its `phase` output.

---
 rtl/phase_shift_loader.sv | 141 ++++++++++++++
 tb/tb_phase_shift_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_shift_loader.sv
// Phase-shifter frame loader: fetches one LUT phase word per element and shifts it out serially, then strobes sle.
// Build option: PHASE_SHIFT_LOADER_PARITY_EN appends an odd-parity bit to every word.
module phase_shift_loader #(
  parameter int NUM_ELEM = 16,
  parameter int SCLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] teta_in,
  output logic       busy,
  output logic       done,
  output logic       lut_en,
  output logic [5:0] lut_teta,
  output logic [3:0] lut_piv,
  input  logic [4:0] lut_phase,
  output logic       sclk,
  output logic       sdata,
  output logic       sle
);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCH  | two cycles: LUT enabled, then phase word captured
  // SHIFT  | serialising the current word, MSB first
  // LATCH  | sle strobe with sclk low
  // DONE   | one-cycle done pulse

`ifdef PHASE_SHIFT_LOADER_PARITY_EN
  localparam int W = 6;
`else
  localparam int W = 5;
`endif

  localparam logic [3:0] PIV_LAST = 4'(NUM_ELEM - 1);
  localparam logic [8:0] HALF_TC  = 9'(SCLK_DIV - 1);
  localparam logic [8:0] LATCH_TC = 9'(2 * SCLK_DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(W - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_LATCH, S_DONE} state_t;

  state_t         state;
  logic [W-1:0]   shreg;
  logic [W-1:0]   word_in;
  logic [8:0]     tmr;
  logic [2:0]     bit_cnt;
  logic           fetch2;

`ifdef PHASE_SHIFT_LOADER_PARITY_EN
  assign word_in = {lut_phase, ~^lut_phase};
`else
  assign word_in = lut_phase;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      lut_en   <= 1'b0;
      lut_teta <= '0;
      lut_piv  <= '0;
      sclk     <= 1'b0;
      sdata    <= 1'b0;
      sle      <= 1'b0;
      shreg    <= '0;
      tmr      <= '0;
      bit_cnt  <= '0;
      fetch2   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            lut_teta <= teta_in;
            lut_piv  <= PIV_LAST;
            busy     <= 1'b1;
            lut_en   <= 1'b1;
            fetch2   <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!fetch2) begin
            fetch2 <= 1'b1;
          end else begin
            fetch2  <= 1'b0;
            lut_en  <= 1'b0;
            shreg   <= word_in;
            sdata   <= word_in[W-1];
            bit_cnt <= LAST_BIT;
            tmr     <= HALF_TC;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (tmr != '0) begin
            tmr <= tmr - 9'd1;
          end else if (!sclk) begin
            sclk <= 1'b1;
            tmr  <= HALF_TC;
          end else begin
            // falling sclk edge: next bit (or next element) is set up while sclk is low
            sclk <= 1'b0;
            tmr  <= HALF_TC;
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 3'd1;
              shreg   <= {shreg[W-2:0], 1'b0};
              sdata   <= shreg[W-2];
            end else if (lut_piv == '0) begin
              sle   <= 1'b1;
              sdata <= 1'b0;
              tmr   <= LATCH_TC;
              state <= S_LATCH;
            end else begin
              lut_piv <= lut_piv - 4'd1;
              lut_en  <= 1'b1;
              state   <= S_FETCH;
            end
          end
        end
        S_LATCH: begin
          if (tmr != '0) begin
            tmr <= tmr - 9'd1;
          end else begin
            sle   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_shift_loader.sv
// Self-checking bench for phase_shift_loader: LUT model, serial-word scoreboard and frame timing checks.
// Honours PHASE_SHIFT_LOADER_PARITY_EN for the expected word length.
module tb_phase_shift_loader;

  localparam int NE = 16;
  localparam int SD = 2;
`ifdef PHASE_SHIFT_LOADER_PARITY_EN
  localparam int W = 6;
`else
  localparam int W = 5;
`endif
  localparam int BUSY_EXP = NE * (2 + 2 * W * SD) + 2 * SD;
  localparam int BUSY_MIN = 1 * (2 + 2 * W * 1) + 2 * 1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] teta_in;
  logic       busy, done, lut_en, sclk, sdata, sle;
  logic [5:0] lut_teta;
  logic [3:0] lut_piv;
  wire  [4:0] lut_phase;

  logic       start_m;
  logic [5:0] teta_m;
  logic       busy_m, done_m, lut_en_m, sclk_m, sdata_m, sle_m;
  logic [5:0] lut_teta_m;
  logic [3:0] lut_piv_m;
  wire  [4:0] lut_phase_m;

  int n_checks = 0;
  int n_fail   = 0;

  assign lut_phase   = lut_en   ? 5'({2'b00, lut_piv}   + lut_teta)   : 5'bzzzzz;
  assign lut_phase_m = lut_en_m ? 5'({2'b00, lut_piv_m} + lut_teta_m) : 5'bzzzzz;

  phase_shift_loader #(.NUM_ELEM(NE), .SCLK_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .teta_in(teta_in),
    .busy(busy), .done(done), .lut_en(lut_en), .lut_teta(lut_teta),
    .lut_piv(lut_piv), .lut_phase(lut_phase), .sclk(sclk), .sdata(sdata), .sle(sle)
  );

  phase_shift_loader #(.NUM_ELEM(1), .SCLK_DIV(1)) dut_min (
    .clk(clk), .rst_n(rst_n), .start(start_m), .teta_in(teta_m),
    .busy(busy_m), .done(done_m), .lut_en(lut_en_m), .lut_teta(lut_teta_m),
    .lut_piv(lut_piv_m), .lut_phase(lut_phase_m), .sclk(sclk_m), .sdata(sdata_m), .sle(sle_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_word(input logic [4:0] ph);
`ifdef PHASE_SHIFT_LOADER_PARITY_EN
    return {ph, ~^ph};
`else
    return ph;
`endif
  endfunction

  logic [W-1:0] sb[$];

  task automatic push_frame(input logic [5:0] t);
    for (int p = NE - 1; p >= 0; p--) sb.push_back(exp_word(5'((p + int'(t)) % 32)));
  endtask

  // ---------------- monitor / scoreboard consumer ----------------
  logic [W-1:0] acc, exp_w;
  int   nbits = 0, words_rx = 0, busy_run = 0, busy_len_last = 0, done_cnt = 0;
  int   both_high = 0, sle_run = 0, sle_len_last = 0, sle_pulses = 0, sle_bad = 0;
  int   stab_bad = 0, sdata_age = 0;
  logic sclk_p = 0, sdata_p = 0, busy_p = 0, sle_p = 0, done_after = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0; busy_run = 0; sle_run = 0; sdata_age = 0;
      sclk_p = 0; sdata_p = 0; busy_p = 0; sle_p = 0;
    end else begin
      if (sdata !== sdata_p) sdata_age = 1; else sdata_age++;
      if (sclk && sclk_p && (sdata !== sdata_p)) stab_bad++;
      if (sclk && !sclk_p) begin
        if (sdata_age <= SD) stab_bad++;
        acc = {acc[W-2:0], sdata};
        nbits++;
        if (nbits == W) begin
          nbits = 0;
          words_rx++;
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL word_unexpected: got %h, expected no word", acc);
          end else begin
            exp_w = sb.pop_front();
            if (acc !== exp_w) begin
              n_fail++;
              $display("FAIL serial_word: got %h, expected %h", acc, exp_w);
            end
          end
        end
      end
      if (busy) busy_run++;
      if (busy_p && !busy) begin
        busy_len_last = busy_run;
        busy_run = 0;
        done_after = done;
      end
      if (done) done_cnt++;
      if (busy && done) both_high++;
      if (sle) begin
        sle_run++;
        if (sclk || nbits != 0) sle_bad++;
      end
      if (sle && !sle_p) sle_pulses++;
      if (!sle && sle_p) begin
        sle_len_last = sle_run;
        sle_run = 0;
      end
      sclk_p = sclk; sdata_p = sdata; busy_p = busy; sle_p = sle;
    end
  end

  // ---------------- stimulus helpers (no checks) ----------------
  task automatic start_frame(input logic [5:0] t);
    @(negedge clk);
    teta_in = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; teta_in = '0; start_m = 1'b0; teta_m = '0;
    #12;
    n_checks++;
    if ({busy, done, lut_en, lut_teta, lut_piv, sclk, sdata, sle} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {busy, done, lut_en, lut_teta, lut_piv, sclk, sdata, sle});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_and_check_frame(input logic [5:0] t, input string tag);
    bit ok;
    int rx0, sp0;
    rx0 = words_rx; sp0 = sle_pulses;
    push_frame(t);
    start_frame(t);
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout: done not seen, expected within 2000 cycles", tag); end
    n_checks++;
    if (busy_len_last != BUSY_EXP) begin
      n_fail++; $display("FAIL %s_busy_len: got %0d, expected %0d", tag, busy_len_last, BUSY_EXP);
    end
    n_checks++;
    if (done_after !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL %s_done_pulse: after-busy %b now %b, expected 1 then 0", tag, done_after, done);
    end
    n_checks++;
    if (words_rx - rx0 != NE || sb.size() != 0) begin
      n_fail++; $display("FAIL %s_word_count: got %0d left %0d, expected %0d left 0", tag, words_rx - rx0, sb.size(), NE);
    end
    n_checks++;
    if (sle_pulses - sp0 != 1 || sle_len_last != 2 * SD) begin
      n_fail++; $display("FAIL %s_sle: pulses %0d len %0d, expected 1 len %0d", tag, sle_pulses - sp0, sle_len_last, 2 * SD);
    end
    n_checks++;
    if (lut_teta !== t || lut_piv !== 4'd0) begin
      n_fail++; $display("FAIL %s_lut_regs: teta %0d piv %0d, expected %0d and 0", tag, lut_teta, lut_piv, t);
    end
  endtask

  task automatic test_full_frame;
    run_and_check_frame(6'd10, "full");
    n_checks++;
    if (sle_bad != 0 || stab_bad != 0 || both_high != 0) begin
      n_fail++; $display("FAIL full_protocol: sle_bad %0d stab_bad %0d both_high %0d, expected 0 0 0", sle_bad, stab_bad, both_high);
    end
  endtask

  task automatic test_patterns;
    run_and_check_frame(6'd22, "pat22");
    run_and_check_frame(6'd17, "pat17");
    run_and_check_frame(6'd63, "pat63");
  endtask

  task automatic test_angle_change;
    bit ok;
    push_frame(6'd10);
    start_frame(6'd10);
    repeat (98) @(negedge clk);
    teta_in = 6'd40;
    @(negedge clk);
    n_checks++;
    if (lut_teta !== 6'd10) begin n_fail++; $display("FAIL angle_hold: lut_teta %0d, expected 10", lut_teta); end
    wait_done(ok);
    n_checks++;
    if (!ok || sb.size() != 0) begin n_fail++; $display("FAIL angle_frame1: ok %b left %0d, expected 1 and 0", ok, sb.size()); end
    run_and_check_frame(6'd40, "angle40");
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2;
    int d0;
    d0 = done_cnt;
    push_frame(6'd10);
    push_frame(6'd10);
    @(negedge clk);
    teta_in = 6'd10;
    start = 1'b1;
    wait_done(ok1);
    n_checks++;
    if (!ok1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL held_idle_gap: ok %b busy %b done %b, expected 1 0 0", ok1, busy, done);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL held_restart: busy %b, expected 1", busy); end
    start = 1'b0;
    wait_done(ok2);
    repeat (20) @(negedge clk);
    n_checks++;
    if (!ok2 || busy !== 1'b0 || done_cnt - d0 != 2 || sb.size() != 0) begin
      n_fail++; $display("FAIL held_two_frames: ok %b busy %b done pulses %0d left %0d, expected 1 0 2 0", ok2, busy, done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_reset_mid_shift;
    bit found;
    int sp0;
    found = 1'b0;
    sp0 = sle_pulses;
    push_frame(6'd10);
    start_frame(6'd10);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy && lut_piv == 4'd5 && !lut_en) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rst_reach_elem5: not reached, expected element 5 shifting"); end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, lut_en, lut_teta, lut_piv, sclk, sdata, sle} !== 16'h0) begin
      n_fail++; $display("FAIL rst_async_outputs: got %h, expected 0",
                         {busy, done, lut_en, lut_teta, lut_piv, sclk, sdata, sle});
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sle_pulses != sp0) begin n_fail++; $display("FAIL rst_no_sle: pulses %0d, expected %0d", sle_pulses, sp0); end
    run_and_check_frame(6'd10, "after_rst");
  endtask

  task automatic test_min_config;
    int blen, hi, consec, toggles, piv_bad;
    bit seen_done;
    logic prev;
    logic [W-1:0] am;
    blen = 0; hi = 0; consec = 0; toggles = 0; piv_bad = 0; seen_done = 0; prev = 0; am = '0;
    @(negedge clk);
    teta_m = 6'd37;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done_m) begin seen_done = 1'b1; break; end
      if (busy_m) begin
        blen++;
        if (sclk_m !== prev) toggles++;
        if (sclk_m) begin
          hi++;
          if (prev) consec++;
          if (!prev) am = {am[W-2:0], sdata_m};
        end
      end
      if (lut_piv_m !== 4'd0) piv_bad++;
      prev = sclk_m;
      @(negedge clk);
    end
    n_checks++;
    if (!seen_done || blen != BUSY_MIN) begin
      n_fail++; $display("FAIL min_busy_len: done %b busy %0d, expected 1 and %0d", seen_done, blen, BUSY_MIN);
    end
    n_checks++;
    if (piv_bad != 0) begin n_fail++; $display("FAIL min_piv: nonzero cycles %0d, expected 0", piv_bad); end
    n_checks++;
    if (hi != W || consec != 0 || toggles != 2 * W) begin
      n_fail++; $display("FAIL min_sclk: high %0d consec %0d toggles %0d, expected %0d 0 %0d", hi, consec, toggles, W, 2 * W);
    end
    n_checks++;
    if (am !== exp_word(5'd5)) begin n_fail++; $display("FAIL min_word: got %h, expected %h", am, exp_word(5'd5)); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_patterns();
    test_angle_change();
    test_back_to_back();
    test_reset_mid_shift();
    test_min_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
